// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared constants and the rate accumulator step for the audio sample pacer
// Contents:
//   ACC_WIDTH      width of the fractional rate accumulator
//   UNDERRUN_WIDTH width of the saturating underrun counter
//   acc_step()     one accumulator update, returns {wrap, next_acc}
package audio_pkg;

  localparam int ACC_WIDTH      = 32;
  localparam int UNDERRUN_WIDTH = 16;

  // Adds the sample rate to the phase accumulator and wraps it modulo the
  // pixel clock frequency. The sum is formed one bit wider so a large
  // accumulator value cannot overflow before the compare.
  function automatic logic [ACC_WIDTH:0] acc_step(
    input logic [ACC_WIDTH-1:0] acc,
    input logic [ACC_WIDTH-1:0] rate,
    input logic [ACC_WIDTH-1:0] period
  );
    logic [ACC_WIDTH:0] sum;
    logic [ACC_WIDTH:0] diff;
    sum  = {1'b0, acc} + {1'b0, rate};
    diff = sum - {1'b0, period};
    if (sum >= {1'b0, period}) begin
      acc_step = {1'b1, diff[ACC_WIDTH-1:0]};
    end else begin
      acc_step = {1'b0, sum[ACC_WIDTH-1:0]};
    end
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - small synchronous FIFO holding stereo sample words
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset, flushes the FIFO
//   wr_valid_i  producer offers a word
//   wr_ready_o  FIFO not full (depends on the current level only)
//   wr_data_i   word to store
//   rd_pop_i    consume the head word; ignored while empty
//   rd_data_o   head word
//   level_o     current occupancy, 0..DEPTH
module audio_sample_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_pop_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic [$clog2(DEPTH):0]  level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        full;
  logic        empty;
  logic        do_push;
  logic        do_pop;

  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign wr_ready_o = !full;
  assign do_push    = wr_valid_i && !full;
  assign do_pop     = rd_pop_i && !empty;
  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign level_o    = wr_ptr_q - rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/audio_sample_pacer.sv
// rtl/audio_sample_pacer.sv - paces buffered stereo samples to an exact-average audio rate strobe
// Ports:
//   clk_pixel       pixel clock, sole clock
//   reset_n         asynchronous active-low reset
//   in_valid        producer has a stereo sample
//   in_ready        FIFO can accept a sample (not full)
//   in_left         signed left sample
//   in_right        signed right sample
//   clk_audio       one-cycle sample strobe
//   audio_left      attenuated left word, valid from the strobe cycle onward
//   audio_right     attenuated right word
//   fifo_level      current FIFO occupancy
//   underrun_count  saturating count of strobes that found the FIFO empty
module audio_sample_pacer
  import audio_pkg::*;
#(
  parameter int PIXEL_CLOCK_HZ    = 25200000,
  parameter int AUDIO_RATE        = 48000,
  parameter int AUDIO_BIT_WIDTH   = 16,
  parameter int FIFO_DEPTH        = 8,
  parameter int ATTENUATION_SHIFT = 9,
  // Reset value of the underrun counter; nonzero only for debug bring-up.
  parameter logic [UNDERRUN_WIDTH-1:0] UNDERRUN_PRESET = '0
) (
  input  logic                              clk_pixel,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [AUDIO_BIT_WIDTH-1:0] in_left,
  input  logic signed [AUDIO_BIT_WIDTH-1:0] in_right,
  output logic                              clk_audio,
  output logic signed [AUDIO_BIT_WIDTH-1:0] audio_left,
  output logic signed [AUDIO_BIT_WIDTH-1:0] audio_right,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic [UNDERRUN_WIDTH-1:0]         underrun_count
);

  typedef struct packed {
    logic signed [AUDIO_BIT_WIDTH-1:0] left;
    logic signed [AUDIO_BIT_WIDTH-1:0] right;
  } stereo_sample_t;

  localparam logic [ACC_WIDTH-1:0] RATE   = ACC_WIDTH'(AUDIO_RATE);
  localparam logic [ACC_WIDTH-1:0] PERIOD = ACC_WIDTH'(PIXEL_CLOCK_HZ);
  localparam logic [UNDERRUN_WIDTH-1:0] UNDERRUN_MAX = '1;

  logic [ACC_WIDTH-1:0]              acc_q, acc_d;
  logic [ACC_WIDTH:0]                acc_next;
  logic                              strobe_next;
  logic                              clk_audio_q, clk_audio_d;
  logic signed [AUDIO_BIT_WIDTH-1:0] left_q, left_d;
  logic signed [AUDIO_BIT_WIDTH-1:0] right_q, right_d;
  logic [UNDERRUN_WIDTH-1:0]         under_q, under_d;
  stereo_sample_t                    wr_sample;
  stereo_sample_t                    head;

  always_comb begin
    wr_sample.left  = in_left;
    wr_sample.right = in_right;
  end

  // The pop uses the same strobe_next that raises clk_audio, so the popped
  // word lands in the output registers on the strobe edge itself.
  audio_sample_fifo #(
    .DATA_WIDTH (2 * AUDIO_BIT_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_pixel),
    .rst_ni     (reset_n),
    .wr_valid_i (in_valid),
    .wr_ready_o (in_ready),
    .wr_data_i  (wr_sample),
    .rd_pop_i   (strobe_next),
    .rd_data_o  (head),
    .level_o    (fifo_level)
  );

  always_comb begin
    acc_next    = acc_step(acc_q, RATE, PERIOD);
    strobe_next = acc_next[ACC_WIDTH];
    acc_d       = acc_next[ACC_WIDTH-1:0];
    clk_audio_d = strobe_next;
    left_d      = left_q;
    right_d     = right_q;
    under_d     = under_q;
    if (strobe_next) begin
      if (fifo_level != '0) begin
        left_d  = head.left >>> ATTENUATION_SHIFT;
        right_d = head.right >>> ATTENUATION_SHIFT;
      end else if (under_q != UNDERRUN_MAX) begin
        // A push landing in this same cycle is still an underrun; that word
        // waits in the FIFO for the next strobe.
        under_d = under_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      clk_audio_q <= 1'b0;
      left_q      <= '0;
      right_q     <= '0;
      under_q     <= UNDERRUN_PRESET;
    end else begin
      acc_q       <= acc_d;
      clk_audio_q <= clk_audio_d;
      left_q      <= left_d;
      right_q     <= right_d;
      under_q     <= under_d;
    end
  end

  assign clk_audio      = clk_audio_q;
  assign audio_left     = left_q;
  assign audio_right    = right_q;
  assign underrun_count = under_q;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// tb/tb_audio_sample_pacer.sv - self-checking bench for audio_sample_pacer
module tb_audio_sample_pacer;

  localparam int P1    = 25200000;
  localparam int P2    = 27000000;
  localparam int R     = 48000;
  localparam int DEPTH = 8;
  localparam int SH    = 9;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  logic        reset_n, reset_f_n;
  logic        in_valid, in_valid_f;
  logic [15:0] in_left, in_right, in_left_f, in_right_f;
  logic        in_ready, in_ready_f;
  logic        clk_audio, clk_audio_f;
  logic [15:0] audio_left, audio_right, audio_left_f, audio_right_f;
  logic [LW-1:0] fifo_level, fifo_level_f;
  logic [15:0] underrun_count, underrun_count_f;

  audio_sample_pacer #(
    .PIXEL_CLOCK_HZ(P1), .AUDIO_RATE(R), .AUDIO_BIT_WIDTH(16),
    .FIFO_DEPTH(DEPTH), .ATTENUATION_SHIFT(SH)
  ) dut (
    .clk_pixel(clk_pixel), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_left(in_left), .in_right(in_right), .clk_audio(clk_audio),
    .audio_left(audio_left), .audio_right(audio_right),
    .fifo_level(fifo_level), .underrun_count(underrun_count)
  );

  audio_sample_pacer #(
    .PIXEL_CLOCK_HZ(P2), .AUDIO_RATE(R), .AUDIO_BIT_WIDTH(16),
    .FIFO_DEPTH(DEPTH), .ATTENUATION_SHIFT(SH), .UNDERRUN_PRESET(16'hFFFE)
  ) dut_f (
    .clk_pixel(clk_pixel), .reset_n(reset_f_n), .in_valid(in_valid_f), .in_ready(in_ready_f),
    .in_left(in_left_f), .in_right(in_right_f), .clk_audio(clk_audio_f),
    .audio_left(audio_left_f), .audio_right(audio_right_f),
    .fifo_level(fifo_level_f), .underrun_count(underrun_count_f)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: cycle index since reset release, queue of samples.
  int          cyc, cyc_f;
  logic [31:0] mq[$];
  logic        m_strobe, m_push, f_strobe;
  logic [15:0] m_left, m_right, m_under, f_under;

  // Strobe on edge n when floor(n*R/P) steps up: exact-average rate R out of P.
  function automatic bit is_strobe(input int n, input longint p);
    return (n > 0) && (((longint'(n) * R) / p) != ((longint'(n - 1) * R) / p));
  endfunction

  // floor(v / 2^SH) on the signed sample value.
  function automatic logic [15:0] atten(input logic [15:0] x);
    int v;
    int q;
    v = int'($signed(x));
    if (v >= 0) q = v / (1 << SH);
    else        q = -((-v + (1 << SH) - 1) / (1 << SH));
    return 16'(q);
  endfunction

  task automatic model_clear();
    mq.delete();
    cyc      = 0;
    m_strobe = 1'b0;
    m_left   = '0;
    m_right  = '0;
    m_under  = '0;
  endtask

  // One clock: advance the model on the rising edge, return at the falling edge.
  task automatic step();
    logic [31:0] s;
    @(posedge clk_pixel);
    if (reset_n) begin
      cyc++;
      m_strobe = is_strobe(cyc, P1);
      m_push   = in_valid && (mq.size() < DEPTH);
      if (m_strobe) begin
        if (mq.size() > 0) begin
          s       = mq.pop_front();
          m_left  = atten(s[31:16]);
          m_right = atten(s[15:0]);
        end else if (m_under != 16'hFFFF) begin
          m_under = m_under + 16'd1;
        end
      end
      if (m_push) mq.push_back({in_left, in_right});
    end
    if (reset_f_n) begin
      cyc_f++;
      f_strobe = is_strobe(cyc_f, P2);
      if (f_strobe && f_under != 16'hFFFF) f_under = f_under + 16'd1;
    end
    @(negedge clk_pixel);
  endtask

  task automatic apply_reset();
    #2 reset_n = 1'b0;
    model_clear();
    repeat (3) step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1; reset_f_n = 1'b1;
    in_valid = 1'b0; in_left = '0; in_right = '0;
    in_valid_f = 1'b0; in_left_f = '0; in_right_f = '0;
    #1 reset_n = 1'b0; reset_f_n = 1'b0;
    model_clear();
    cyc_f = 0; f_strobe = 1'b0; f_under = 16'hFFFE;
    repeat (3) step();
    checks++; if (clk_audio !== 1'b0) begin errors++; $display("FAIL reset_clk_audio: got %b expected 0", clk_audio); end
    checks++; if (audio_left !== 16'h0) begin errors++; $display("FAIL reset_left: got %h expected 0000", audio_left); end
    checks++; if (audio_right !== 16'h0) begin errors++; $display("FAIL reset_right: got %h expected 0000", audio_right); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (underrun_count !== 16'h0) begin errors++; $display("FAIL reset_underrun: got %h expected 0000", underrun_count); end
    checks++; if (underrun_count_f !== 16'hFFFE) begin errors++; $display("FAIL reset_underrun_preset: got %h expected fffe", underrun_count_f); end
    checks++; if (clk_audio_f !== 1'b0) begin errors++; $display("FAIL reset_clk_audio_f: got %b expected 0", clk_audio_f); end
    reset_n = 1'b1; reset_f_n = 1'b1;
  endtask

  task automatic test_strobe_rates();
    int me[$];
    int fe[$];
    int mm, bad, cnt, sp, prev;
    logic [15:0] u_at, f1, f2;
    mm = 0; u_at = '0; f1 = '0; f2 = '0;
    for (int i = 0; i < 54000; i++) begin
      step();
      if (clk_audio !== m_strobe) mm++;
      if (clk_audio_f !== f_strobe) mm++;
      if (clk_audio) me.push_back(cyc);
      if (clk_audio_f) begin
        fe.push_back(cyc_f);
        if (fe.size() == 1) f1 = underrun_count_f;
        if (fe.size() == 2) f2 = underrun_count_f;
      end
      if (cyc == 52500) u_at = underrun_count;
    end
    checks++; if (mm != 0) begin errors++; $display("FAIL rate_strobe_pattern: got %0d mismatched cycles expected 0", mm); end
    cnt = 0; bad = 0; prev = 0;
    foreach (me[k]) if (me[k] <= 52500) begin
      cnt++;
      if (me[k] - prev != 525) bad++;
      prev = me[k];
    end
    checks++; if (cnt != 100) begin errors++; $display("FAIL int_strobe_count: got %0d expected 100", cnt); end
    checks++; if (me.size() == 0 || me[0] != 525) begin errors++; $display("FAIL int_first_strobe: got %0d expected 525", (me.size() == 0) ? -1 : me[0]); end
    checks++; if (bad != 0) begin errors++; $display("FAIL int_spacing: got %0d bad spacings expected 0", bad); end
    checks++; if (u_at !== 16'd100) begin errors++; $display("FAIL int_underruns: got %0d expected 100", u_at); end
    checks++; if (fe.size() != 96) begin errors++; $display("FAIL frac_strobe_count: got %0d expected 96", fe.size()); end
    bad = 0; prev = 0;
    foreach (fe[k]) begin
      sp = fe[k] - prev;
      if (sp != (((k % 2) == 0) ? 563 : 562)) bad++;
      prev = fe[k];
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL frac_spacing: got %0d bad spacings expected 0", bad); end
    checks++; if (f1 !== 16'hFFFF) begin errors++; $display("FAIL sat_first: got %h expected ffff", f1); end
    checks++; if (f2 !== 16'hFFFF) begin errors++; $display("FAIL sat_second: got %h expected ffff", f2); end
    checks++; if (underrun_count_f !== 16'hFFFF) begin errors++; $display("FAIL sat_final: got %h expected ffff", underrun_count_f); end
  endtask

  task automatic test_random_stream();
    int mode;
    logic [53:0] got, exp;
    for (int c = 0; c < 6; c++) begin
      mode = (c == 0) ? 0 : (c == 1) ? 2 : (c == 2) ? 1 : int'($urandom_range(0, 2));
      for (int i = 0; i < 600; i++) begin
        case (mode)
          0:       in_valid = 1'b0;
          1:       in_valid = 1'b1;
          default: in_valid = ($urandom_range(0, 199) == 0);
        endcase
        in_left  = 16'($urandom);
        in_right = 16'($urandom);
        step();
        got = {clk_audio, in_ready, fifo_level, underrun_count, audio_left, audio_right};
        exp = {m_strobe, (mq.size() < DEPTH), LW'(mq.size()), m_under, m_left, m_right};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random_stream cycle %0d: got %h expected %h", cyc, got, exp);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_stream();
    int n;
    apply_reset();
    in_valid = 1'b1; in_left = 16'h7FFF; in_right = 16'h8000;
    repeat (20) step();
    checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL full_level: got %0d expected 8", fifo_level); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin step(); n++; end while (!clk_audio && n < 700);
      checks++; if (clk_audio !== 1'b1) begin errors++; $display("FAIL full_strobe_timeout: got %b expected 1", clk_audio); end
      if (k == 0) begin
        checks++; if (cyc != 525) begin errors++; $display("FAIL full_first_strobe: got %0d expected 525", cyc); end
      end
      checks++; if (audio_left !== 16'h003F) begin errors++; $display("FAIL full_left: got %h expected 003f", audio_left); end
      checks++; if (audio_right !== 16'hFFC0) begin errors++; $display("FAIL full_right: got %h expected ffc0", audio_right); end
      checks++; if (fifo_level !== 4'd7) begin errors++; $display("FAIL pop_cycle_level: got %0d expected 7", fifo_level); end
      step();
      checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL refill_level: got %0d expected 8", fifo_level); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL refill_in_ready: got %b expected 0", in_ready); end
    end
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL full_underrun: got %0d expected 0", underrun_count); end
  endtask

  task automatic test_idle_underrun();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (fifo_level != 0 && n < 10 * 525) begin step(); n++; end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL drain_level: got %0d expected 0", fifo_level); end
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin step(); n++; end while (!clk_audio && n < 700);
      checks++; if (clk_audio !== 1'b1) begin errors++; $display("FAIL idle_strobe_timeout: got %b expected 1", clk_audio); end
    end
    checks++; if (underrun_count !== 16'd3) begin errors++; $display("FAIL idle_underrun: got %0d expected 3", underrun_count); end
    checks++; if (audio_left !== 16'h003F) begin errors++; $display("FAIL idle_hold_left: got %h expected 003f", audio_left); end
    checks++; if (audio_right !== 16'hFFC0) begin errors++; $display("FAIL idle_hold_right: got %h expected ffc0", audio_right); end
  endtask

  task automatic test_empty_collision();
    int n;
    logic [15:0] x, y;
    n = 0;
    while (!is_strobe(cyc + 1, P1) && n < 600) begin step(); n++; end
    x = 16'($urandom_range(16'h4000, 16'h7FFF));
    y = 16'($urandom) | 16'h8000;
    in_valid = 1'b1; in_left = x; in_right = y;
    step();
    in_valid = 1'b0;
    checks++; if (clk_audio !== 1'b1) begin errors++; $display("FAIL coll_strobe: got %b expected 1", clk_audio); end
    checks++; if (underrun_count !== 16'd4) begin errors++; $display("FAIL coll_underrun: got %0d expected 4", underrun_count); end
    checks++; if (audio_left !== 16'h003F) begin errors++; $display("FAIL coll_no_bypass: got %h expected 003f", audio_left); end
    checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL coll_stored: got %0d expected 1", fifo_level); end
    n = 0;
    do begin step(); n++; end while (!clk_audio && n < 700);
    checks++; if (clk_audio !== 1'b1) begin errors++; $display("FAIL coll_next_timeout: got %b expected 1", clk_audio); end
    checks++; if (audio_left !== atten(x)) begin errors++; $display("FAIL coll_left: got %h expected %h", audio_left, atten(x)); end
    checks++; if (audio_right !== atten(y)) begin errors++; $display("FAIL coll_right: got %h expected %h", audio_right, atten(y)); end
    checks++; if (underrun_count !== 16'd4) begin errors++; $display("FAIL coll_underrun_after: got %0d expected 4", underrun_count); end
  endtask

  task automatic test_reset_midstream();
    int n;
    in_valid = 1'b1;
    repeat (5) begin
      in_left  = 16'($urandom_range(16'h4000, 16'h7FFF));
      in_right = 16'($urandom_range(16'h4000, 16'h7FFF));
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    checks++; if (fifo_level !== 4'd5) begin errors++; $display("FAIL mid_level_before: got %0d expected 5", fifo_level); end
    checks++; if (audio_left !== m_left) begin errors++; $display("FAIL mid_left_before: got %h expected %h", audio_left, m_left); end
    #2 reset_n = 1'b0;
    model_clear();
    #1;
    checks++; if (clk_audio !== 1'b0) begin errors++; $display("FAIL mid_clk_audio: got %b expected 0", clk_audio); end
    checks++; if (audio_left !== 16'h0) begin errors++; $display("FAIL mid_left: got %h expected 0000", audio_left); end
    checks++; if (audio_right !== 16'h0) begin errors++; $display("FAIL mid_right: got %h expected 0000", audio_right); end
    checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL mid_level: got %0d expected 0", fifo_level); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL mid_underrun: got %0d expected 0", underrun_count); end
    repeat (2) step();
    reset_n = 1'b1;
    n = 0;
    do begin step(); n++; end while (!clk_audio && n < 700);
    checks++; if (n != 525) begin errors++; $display("FAIL mid_first_strobe: got %0d expected 525", n); end
    checks++; if (underrun_count !== 16'd1) begin errors++; $display("FAIL mid_underrun_after: got %0d expected 1", underrun_count); end
    checks++; if (audio_left !== 16'h0) begin errors++; $display("FAIL mid_left_after: got %h expected 0000", audio_left); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_strobe_rates();
    test_random_stream();
    test_full_stream();
    test_idle_underrun();
    test_empty_collision();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_sample_pacer.md
Name: audio_sample_pacer

Overview:
Sits between the audio sample producer (tone/sawtooth generator) and the hdmi core's audio inputs, in the clk_pixel domain.
Generates an exact-average AUDIO_RATE sample strobe (clk_audio) from the pixel clock with a fractional accumulator, so no hand-tuned divide counter is needed.
Buffers producer samples in a small stereo FIFO and presents one attenuated stereo word per strobe.
Counts underruns for debug LEDs.

Parameters:
PIXEL_CLOCK_HZ, 25200000, pixel clock frequency; must be > 2*AUDIO_RATE.
AUDIO_RATE, 48000, output sample rate in Hz.
AUDIO_BIT_WIDTH, 16, signed sample width per channel.
FIFO_DEPTH, 8, stereo entries; power of two, >= 2.
ATTENUATION_SHIFT, 9, arithmetic right shift applied to output samples; 0 = none.

Ports:
clk_pixel  in  1  pixel clock; sole clock.
reset_n  in  1  asynchronous active-low reset.
in_valid  in  1  producer has a stereo sample.
in_ready  out  1  FIFO can accept a sample; equals !full.
in_left  in  AUDIO_BIT_WIDTH  signed left sample.
in_right  in  AUDIO_BIT_WIDTH  signed right sample.
clk_audio  out  1  one-cycle sample strobe to the hdmi core.
audio_left  out  AUDIO_BIT_WIDTH  attenuated left word; valid from the strobe cycle onward.
audio_right  out  AUDIO_BIT_WIDTH  attenuated right word.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
underrun_count  out  16  saturating count of strobes that found the FIFO empty.

Behaviour:
- Reset (async assert, sync release): acc=0, FIFO flushed (level 0), clk_audio=0, audio_left/right=0, underrun_count=0; in_ready=1. Reset mid-operation discards buffered samples.
- Accumulator, 32-bit unsigned. Each cycle: if acc + AUDIO_RATE >= PIXEL_CLOCK_HZ, then acc <= acc + AUDIO_RATE - PIXEL_CLOCK_HZ and strobe_next=1; else acc <= acc + AUDIO_RATE.
- clk_audio is registered, so the first strobe appears on cycle ceil(PIXEL_CLOCK_HZ/AUDIO_RATE) after reset release. Strobes are never adjacent.
- Push: occurs when in_valid && in_ready. in_ready is computed from the current level only, so a pop in the same cycle does not allow a push into a full FIFO.
- Pop: occurs on the cycle strobe_next=1, if level>0. Output registers load the head sample, right-shifted arithmetically by ATTENUATION_SHIFT, in the same clock edge that raises clk_audio. Sample latency is therefore 0 cycles relative to the strobe.
- Empty at strobe: outputs hold their previous value, underrun_count increments and saturates at 16'hFFFF, and no pop occurs.
- Push while empty in the pop cycle: this is an underrun. The new word is stored and does not bypass the FIFO.
- Simultaneous push and pop when level is between 1 and FIFO_DEPTH-1: level is unchanged.
- Pointer wrap: pointers are $clog2(FIFO_DEPTH)+1 bits. full = MSBs differ and remaining bits equal; empty = pointers equal.
- Outputs are stable between strobes. The hdmi core samples them on clk_audio.

Decomposition:
- audio_pkg: typedef struct packed {logic signed [W-1:0] left, right;} stereo_sample_t, parameterised via the module parameter; constant ACC_WIDTH=32.
- One sub-module, audio_sample_fifo: synchronous FIFO with valid/ready on write, pop strobe on read, level output and async active-low reset.
- Accumulator, output registers and underrun counter stay in audio_sample_pacer.

Test Plan:
- Integer ratio: PIXEL_CLOCK_HZ=25200000, AUDIO_RATE=48000, run 525*100 cycles -> exactly 100 strobes, every spacing 525 cycles, first strobe at cycle 525.
- Fractional ratio: PIXEL_CLOCK_HZ=27000000 -> strobe spacings alternate 563/562, 96 strobes in 54000 cycles.
- Producer always valid, in_left=16'h7FFF, in_right=16'h8000, shift 9 -> audio_left=16'h003F, audio_right=16'hFFC0 at each strobe; fifo_level reaches 8 and in_ready=0 between strobes.
- Producer idle: no pushes for 3 strobes -> underrun_count=3, outputs hold last value; preset counter to 16'hFFFE plus 2 underruns -> saturates at 16'hFFFF.
- Edge collisions: with level=8, hold in_valid through a pop -> no push in the pop cycle, push on the next cycle. With level=0, push coincident with strobe -> underrun counted, word presented at the following strobe.
- Reset mid-stream: assert reset_n=0 with level=5 between strobes -> clk_audio=0, outputs 0 and level 0 immediately. After release, the first strobe comes 525 cycles later.
